// File: rtl/uart_axi_tx_sequencer.sv
// AXI4-Lite master: programs the UART ctrl register, then streams bytes.
// Optional timeout/error logic: define UART_SEQ_TIMEOUT_EN.
module uart_axi_tx_sequencer #(
  parameter logic [31:0] UART_BASE_ADDR = 32'h2000_0000,
  parameter logic [15:0] BAUD_DIV       = 16'd868,
  parameter logic [7:0]  POLL_GAP       = 8'd16,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
  input  logic        s_axi_aclk_i,
  input  logic        s_axi_aresetn_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic [31:0] m_axi_araddr_o,
  output logic        m_axi_arvalid_o,
  output logic        m_axi_rready_o,
  input  logic        m_axi_rvalid_i,
  input  logic [31:0] m_axi_rdata_i,
  output logic [31:0] m_axi_awaddr_o,
  output logic        m_axi_awvalid_o,
  output logic [31:0] m_axi_wdata_o,
  output logic [3:0]  m_axi_wstrb_o,
  output logic        m_axi_wvalid_o,
  output logic        m_axi_bready_o,
  input  logic        m_axi_bvalid_i,
  output logic        busy_o,
  output logic [15:0] sent_count_o,
  output logic        err_o,
  input  logic        err_clr_i
);

  typedef enum logic [2:0] {
    CFG_WR,
    WAIT_BYTE,
    POLL_RD,
    POLL_WAIT,
    DATA_WR
  } state_t;

  localparam logic [31:0] CTRL_ADDR = UART_BASE_ADDR;
  localparam logic [31:0] STAT_ADDR = UART_BASE_ADDR + 32'h4;
  localparam logic [31:0] WDAT_ADDR = UART_BASE_ADDR + 32'hC;

  state_t      state_q;
  logic [7:0]  byte_q;
  logic [7:0]  gap_q;
  logic [15:0] sent_q;
  logic        w_done;
  logic        r_done;
  logic        tmo_hit;
  logic        unused_bits;

  assign w_done       = m_axi_awvalid_o & m_axi_bvalid_i;
  assign r_done       = m_axi_arvalid_o & m_axi_rvalid_i;
  assign busy_o       = (state_q != WAIT_BYTE);
  assign sent_count_o = sent_q;

`ifdef UART_SEQ_TIMEOUT_EN
  logic [15:0] tmo_q;
  logic        err_q;
  logic        tmo_st;

  assign tmo_st  = (state_q == CFG_WR) ||
                   (state_q == POLL_RD) ||
                   (state_q == DATA_WR);
  assign tmo_hit = tmo_st && !w_done && !r_done &&
                   (tmo_q == TIMEOUT_CYCLES);
  assign err_o   = err_q;
  assign unused_bits = ^m_axi_rdata_i[31:1];

  // Cycles spent waiting in a bus state; cleared on every state change.
  always_ff @(posedge s_axi_aclk_i or negedge s_axi_aresetn_i) begin
    if (!s_axi_aresetn_i) begin
      tmo_q <= '0;
    end else if (!tmo_st || tmo_hit || w_done || r_done) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 16'd1;
    end
  end

  // Sticky error; a new timeout beats a simultaneous clear.
  always_ff @(posedge s_axi_aclk_i or negedge s_axi_aresetn_i) begin
    if (!s_axi_aresetn_i) begin
      err_q <= 1'b0;
    end else if (tmo_hit) begin
      err_q <= 1'b1;
    end else if (err_clr_i) begin
      err_q <= 1'b0;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err_o   = 1'b0;
  assign unused_bits = ^{err_clr_i, m_axi_rdata_i[31:1]};
`endif

  // Sequencer FSM with registered bus and stream outputs.
  always_ff @(posedge s_axi_aclk_i or negedge s_axi_aresetn_i) begin
    if (!s_axi_aresetn_i) begin
      state_q         <= CFG_WR;
      byte_q          <= '0;
      gap_q           <= '0;
      sent_q          <= '0;
      byte_ready_o    <= 1'b0;
      m_axi_araddr_o  <= '0;
      m_axi_arvalid_o <= 1'b0;
      m_axi_rready_o  <= 1'b0;
      m_axi_awaddr_o  <= '0;
      m_axi_awvalid_o <= 1'b0;
      m_axi_wdata_o   <= '0;
      m_axi_wstrb_o   <= '0;
      m_axi_wvalid_o  <= 1'b0;
      m_axi_bready_o  <= 1'b0;
    end else begin
      unique case (state_q)
        CFG_WR: begin
          if (tmo_hit) begin
            m_axi_awvalid_o <= 1'b0;
            m_axi_wvalid_o  <= 1'b0;
            m_axi_bready_o  <= 1'b0;
          end else if (!m_axi_awvalid_o) begin
            m_axi_awaddr_o  <= CTRL_ADDR;
            m_axi_wdata_o   <= {BAUD_DIV, 16'h0001};
            m_axi_wstrb_o   <= 4'hF;
            m_axi_awvalid_o <= 1'b1;
            m_axi_wvalid_o  <= 1'b1;
            m_axi_bready_o  <= 1'b1;
          end else if (m_axi_bvalid_i) begin
            m_axi_awvalid_o <= 1'b0;
            m_axi_wvalid_o  <= 1'b0;
            m_axi_bready_o  <= 1'b0;
            byte_ready_o    <= 1'b1;
            state_q         <= WAIT_BYTE;
          end
        end
        WAIT_BYTE: begin
          if (byte_valid_i) begin
            byte_q          <= byte_i;
            byte_ready_o    <= 1'b0;
            m_axi_araddr_o  <= STAT_ADDR;
            m_axi_arvalid_o <= 1'b1;
            m_axi_rready_o  <= 1'b1;
            state_q         <= POLL_RD;
          end
        end
        POLL_RD: begin
          if (tmo_hit) begin
            m_axi_arvalid_o <= 1'b0;
            m_axi_rready_o  <= 1'b0;
            byte_ready_o    <= 1'b1;
            state_q         <= WAIT_BYTE;
          end else if (m_axi_rvalid_i) begin
            m_axi_arvalid_o <= 1'b0;
            m_axi_rready_o  <= 1'b0;
            if (m_axi_rdata_i[0]) begin
              gap_q   <= POLL_GAP;
              state_q <= POLL_WAIT;
            end else begin
              m_axi_awaddr_o  <= WDAT_ADDR;
              m_axi_wdata_o   <= {24'h0, byte_q};
              m_axi_wstrb_o   <= 4'b0001;
              m_axi_awvalid_o <= 1'b1;
              m_axi_wvalid_o  <= 1'b1;
              m_axi_bready_o  <= 1'b1;
              state_q         <= DATA_WR;
            end
          end
        end
        POLL_WAIT: begin
          if (gap_q == 8'd0) begin
            m_axi_araddr_o  <= STAT_ADDR;
            m_axi_arvalid_o <= 1'b1;
            m_axi_rready_o  <= 1'b1;
            state_q         <= POLL_RD;
          end else begin
            gap_q <= gap_q - 8'd1;
          end
        end
        DATA_WR: begin
          if (tmo_hit || m_axi_bvalid_i) begin
            m_axi_awvalid_o <= 1'b0;
            m_axi_wvalid_o  <= 1'b0;
            m_axi_bready_o  <= 1'b0;
            byte_ready_o    <= 1'b1;
            state_q         <= WAIT_BYTE;
            if (!tmo_hit) begin
              sent_q <= sent_q + 16'd1;
            end
          end
        end
        default: begin
          state_q <= CFG_WR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_axi_tx_sequencer.sv
// Directed bench for uart_axi_tx_sequencer with a latency-programmable
// AXI4-Lite slave model and transaction log.
module tb_uart_axi_tx_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  byte_i = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        rready;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic [31:0] awaddr;
  logic        awvalid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        bready;
  logic        bvalid = 1'b0;
  logic        busy;
  logic [15:0] sent;
  logic        err;
  logic        err_clr = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int b_lat = 2;
  int r_lat = 1;
  bit b_hang = 1'b0;
  bit r_hang = 1'b0;
  int full_left = 0;
  int bc = 0;
  int rc = 0;

  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [3:0]  ws_q[$];
  logic [31:0] ra_q[$];
  int          rt_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  uart_axi_tx_sequencer dut (
    .s_axi_aclk_i    (clk),
    .s_axi_aresetn_i (rst_n),
    .byte_i          (byte_i),
    .byte_valid_i    (byte_valid),
    .byte_ready_o    (byte_ready),
    .m_axi_araddr_o  (araddr),
    .m_axi_arvalid_o (arvalid),
    .m_axi_rready_o  (rready),
    .m_axi_rvalid_i  (rvalid),
    .m_axi_rdata_i   (rdata),
    .m_axi_awaddr_o  (awaddr),
    .m_axi_awvalid_o (awvalid),
    .m_axi_wdata_o   (wdata),
    .m_axi_wstrb_o   (wstrb),
    .m_axi_wvalid_o  (wvalid),
    .m_axi_bready_o  (bready),
    .m_axi_bvalid_i  (bvalid),
    .busy_o          (busy),
    .sent_count_o    (sent),
    .err_o           (err),
    .err_clr_i       (err_clr)
  );

  // Slave model: responses are driven and logged on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (bvalid) begin
        bvalid = 1'b0;
        bc = 0;
      end else if (awvalid && !b_hang) begin
        if (bc >= b_lat) begin
          bvalid = 1'b1;
          wa_q.push_back(awaddr);
          wd_q.push_back(wdata);
          ws_q.push_back(wstrb);
        end else begin
          bc++;
        end
      end else if (!awvalid) begin
        bc = 0;
      end
      if (rvalid) begin
        rvalid = 1'b0;
        rdata = '0;
        rc = 0;
      end else if (arvalid && !r_hang) begin
        if (rc >= r_lat) begin
          rvalid = 1'b1;
          rdata = (full_left > 0) ? 32'h1 : 32'h0;
          if (full_left > 0) full_left--;
          ra_q.push_back(araddr);
          rt_q.push_back(cyc);
        end else begin
          rc++;
        end
      end else if (!arvalid) begin
        rc = 0;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bound_fail(input string tag);
    checks++;
    failures++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  task automatic wait_ready(input string tag, input int lim);
    int n = 0;
    while (!byte_ready && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) bound_fail(tag);
  endtask

  task automatic send(input logic [7:0] b);
    byte_i = b;
    byte_valid = 1'b1;
    wait_ready("send_ready", 2000);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  initial begin
    int base;
    int n;
    logic [7:0] b;

    // 1: reset state and control register write
    repeat (3) @(negedge clk);
    chk("rst_awvalid", 32'(awvalid), 32'h0);
    chk("rst_arvalid", 32'(arvalid), 32'h0);
    chk("rst_wvalid", 32'(wvalid), 32'h0);
    chk("rst_ready", 32'(byte_ready), 32'h0);
    chk("rst_count", 32'(sent), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h1);
    chk("rst_awaddr", awaddr, 32'h0);
    chk("rst_wdata", wdata, 32'h0);
    rst_n = 1'b1;
    wait_ready("cfg_ready", 50);
    chk("cfg_nwr", 32'(wa_q.size()), 32'd1);
    chk("cfg_addr", wa_q[0], 32'h2000_0000);
    chk("cfg_data", wd_q[0], 32'h0364_0001);
    chk("cfg_strb", 32'(ws_q[0]), 32'hF);
    chk("cfg_ready1", 32'(byte_ready), 32'h1);
    chk("cfg_busy0", 32'(busy), 32'h0);

    // 2: single byte, status not full
    b_lat = 1;
    r_lat = 1;
    send(8'h41);
    chk("b2_issue_ar", 32'(arvalid), 32'h1);
    chk("b2_ready0", 32'(byte_ready), 32'h0);
    wait_ready("b2_done", 100);
    chk("b2_nrd", 32'(ra_q.size()), 32'd1);
    chk("b2_raddr", ra_q[0], 32'h2000_0004);
    chk("b2_nwr", 32'(wa_q.size()), 32'd2);
    chk("b2_waddr", wa_q[1], 32'h2000_000C);
    chk("b2_wdata", wd_q[1], 32'h0000_0041);
    chk("b2_wstrb", 32'(ws_q[1]), 32'h1);
    chk("b2_count", 32'(sent), 32'd1);

    // 3: tx_full three times, then clear
    r_lat = 0;
    full_left = 3;
    send(8'h5A);
    wait_ready("b3_done", 400);
    chk("b3_nrd", 32'(ra_q.size()), 32'd5);
    for (int i = 2; i < 5; i++) begin
      chk("b3_gap", 32'(rt_q[i] - rt_q[i-1] >= 17), 32'h1);
    end
    chk("b3_nwr", 32'(wa_q.size()), 32'd3);
    chk("b3_wdata", wd_q[2], 32'h0000_005A);
    chk("b3_count", 32'(sent), 32'd2);

    // 4: 300 back-to-back bytes across the counter wrap
    b_lat = 0;
    force dut.sent_q = 16'hFFFF;
    @(negedge clk);
    release dut.sent_q;
    @(negedge clk);
    chk("b4_preload", 32'(sent), 32'hFFFF);
    base = wa_q.size();
    byte_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      b = 8'(i * 7 + 3);
      byte_i = b;
      n = 0;
      while (!byte_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!byte_ready) bound_fail("b4_ready");
      @(negedge clk);
    end
    byte_valid = 1'b0;
    wait_ready("b4_done", 50);
    chk("b4_nwr", 32'(wa_q.size() - base), 32'd300);
    for (int i = 0; i < 300; i++) begin
      b = 8'(i * 7 + 3);
      if (base + i < wa_q.size())
        chk("b4_data", wd_q[base + i], {24'h0, b});
    end
    chk("b4_count", 32'(sent), 32'd299);

`ifdef UART_SEQ_TIMEOUT_EN
    // 5: write response never arrives
    b_hang = 1'b1;
    send(8'h77);
    n = 0;
    while (!err && n < 1300) begin
      @(negedge clk);
      n++;
    end
    if (!err) bound_fail("b5_err");
    chk("b5_err1", 32'(err), 32'h1);
    chk("b5_awvalid", 32'(awvalid), 32'h0);
    chk("b5_wvalid", 32'(wvalid), 32'h0);
    chk("b5_bready", 32'(bready), 32'h0);
    chk("b5_ready", 32'(byte_ready), 32'h1);
    chk("b5_busy", 32'(busy), 32'h0);
    chk("b5_count", 32'(sent), 32'd299);
    b_hang = 1'b0;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("b5_clr", 32'(err), 32'h0);
`else
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("b5_err0", 32'(err), 32'h0);
`endif

    // 6: reset in the middle of a status read
    r_hang = 1'b1;
    send(8'h33);
    repeat (3) @(negedge clk);
    chk("b6_arvalid1", 32'(arvalid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("b6_arvalid0", 32'(arvalid), 32'h0);
    chk("b6_rready0", 32'(rready), 32'h0);
    chk("b6_busy", 32'(busy), 32'h1);
    r_hang = 1'b0;
    @(negedge clk);
    base = wa_q.size();
    rst_n = 1'b1;
    wait_ready("b6_done", 50);
    chk("b6_nwr", 32'(wa_q.size() - base), 32'd1);
    if (wa_q.size() > base)
      chk("b6_addr", wa_q[base], 32'h2000_0000);
    chk("b6_count", 32'(sent), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
